otf_converter_hd: RTL and testbench

OTF_CONVERTER_HD -- requirements
Module: otf_converter_hd

---
 rtl/hd_pkg.sv | 20 ++
 rtl/otf_update_hd.sv | 35 +++
 rtl/otf_converter_hd.sv | 121 ++++++++++++
 tb/tb_otf_converter_hd.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hd_pkg.sv
// Shared definitions for the HD multiplier datapath and the on-the-fly converter:
// signed-digit encodings, converter state type and a digit decode helper.
package hd_pkg;

    // Online signed digit encoding: value = bit[1] - bit[0]; 2'b11 also means zero
    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } otf_state_t;

    // True for both zero encodings (2'b00 and 2'b11)
    function automatic logic dig_is_zero(input logic [1:0] dig);
        return (dig != DIG_POS) && (dig != DIG_NEG);
    endfunction

endpackage

// File: rtl/otf_update_hd.sv
// Next-value logic for the on-the-fly conversion registers Q and QM = Q - 1.
// One signed digit is appended per call; the MSB is dropped to keep W bits.
module otf_update_hd
    import hd_pkg::*;
#(
    parameter int W = 17
) (
    input  logic [1:0]   digit,
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next
);

    // Append the digit to Q/QM; a negative digit borrows through QM
    always_comb begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        case (digit)
            DIG_POS: begin
                q_next  = {q[W-2:0], 1'b1};
                qm_next = {q[W-2:0], 1'b0};
            end
            DIG_NEG: begin
                q_next  = {qm[W-2:0], 1'b1};
                qm_next = {qm[W-2:0], 1'b0};
            end
            default: begin
                q_next  = {q[W-2:0], 1'b0};
                qm_next = {qm[W-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/otf_converter_hd.sv
// On-the-fly converter: turns an MSD-first stream of DIGITS signed digits into a
// DIGITS+1 bit two's-complement word with valid/ready handshakes on both sides.
// Optional feature: define OTF_ZERO_FLAG_EN to add the result_zero output.
module otf_converter_hd
    import hd_pkg::*;
#(
    parameter int DIGITS    = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic [1:0]        p_value,
    input  logic              data_in_vld,
    output logic              data_in_rdy,
    output logic [DIGITS:0]   result,
    output logic              result_vld,
    input  logic              result_rdy
`ifdef OTF_ZERO_FLAG_EN
    ,
    output logic              result_zero
`endif
);

    localparam int W = DIGITS + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DIGITS - 1);

    otf_state_t           state_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [W-1:0]         q_r;
    logic [W-1:0]         qm_r;

    logic                 xfer_s;
    logic [W-1:0]         base_q_s;
    logic [W-1:0]         base_qm_s;
    logic [CNT_WIDTH-1:0] cnt_base_s;
    logic [W-1:0]         q_nxt_s;
    logic [W-1:0]         qm_nxt_s;

    assign data_in_rdy = (state_r == ACCUM) || ((state_r == DONE) && result_rdy);
    assign xfer_s      = data_in_vld && data_in_rdy;
    assign result      = q_r;
    assign result_vld  = (state_r == DONE);

    // A digit taken while leaving DONE starts a new word from the initial Q/QM
    always_comb begin
        base_q_s   = q_r;
        base_qm_s  = qm_r;
        cnt_base_s = cnt_r;
        if (state_r == DONE) begin
            base_q_s   = '0;
            base_qm_s  = '1;
            cnt_base_s = '0;
        end else begin
            base_q_s   = q_r;
            base_qm_s  = qm_r;
            cnt_base_s = cnt_r;
        end
    end

    otf_update_hd #(
        .W (W)
    ) u_update (
        .digit   (p_value),
        .q       (base_q_s),
        .qm      (base_qm_s),
        .q_next  (q_nxt_s),
        .qm_next (qm_nxt_s)
    );

    // Word FSM: accumulate digits, present the result, restart on handoff
    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state_r <= ACCUM;
            cnt_r   <= '0;
            q_r     <= '0;
            qm_r    <= '1;
        end else if (xfer_s) begin
            q_r  <= q_nxt_s;
            qm_r <= qm_nxt_s;
            if (cnt_base_s == LAST_CNT) begin
                state_r <= DONE;
                cnt_r   <= '0;
            end else begin
                state_r <= ACCUM;
                cnt_r   <= cnt_base_s + CNT_WIDTH'(1);
            end
        end else if ((state_r == DONE) && result_rdy) begin
            state_r <= ACCUM;
            cnt_r   <= '0;
            q_r     <= '0;
            qm_r    <= '1;
        end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
            q_r     <= q_r;
            qm_r    <= qm_r;
        end
    end

`ifdef OTF_ZERO_FLAG_EN
    logic zero_r;

    assign result_zero = zero_r;

    // Sticky all-digits-zero flag, restarted on the first digit of each word
    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            zero_r <= 1'b0;
        end else if (xfer_s) begin
            if (cnt_base_s == '0) begin
                zero_r <= dig_is_zero(p_value);
            end else begin
                zero_r <= zero_r & dig_is_zero(p_value);
            end
        end else begin
            zero_r <= zero_r;
        end
    end
`endif

endmodule

// File: tb/tb_otf_converter_hd.sv
// Self-checking bench for otf_converter_hd (DIGITS = 4): table vectors,
// hand-written handshake/reset sequences and randomized traffic against a
// word-level reference model.
module tb_otf_converter_hd;
    import hd_pkg::*;

    localparam int TD  = 4;
    localparam int TCW = 3;

    logic          clk;
    logic          asyn_reset;
    logic [1:0]    p_value;
    logic          data_in_vld;
    logic          data_in_rdy;
    logic [TD:0]   result;
    logic          result_vld;
    logic          result_rdy;
`ifdef OTF_ZERO_FLAG_EN
    logic          result_zero;
`endif

    otf_converter_hd #(
        .DIGITS    (TD),
        .CNT_WIDTH (TCW)
    ) dut (
        .clk         (clk),
        .asyn_reset  (asyn_reset),
        .p_value     (p_value),
        .data_in_vld (data_in_vld),
        .data_in_rdy (data_in_rdy),
        .result      (result),
        .result_vld  (result_vld),
        .result_rdy  (result_rdy)
`ifdef OTF_ZERO_FLAG_EN
        ,
        .result_zero (result_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: digits of the current word, pending output word
    int   word_q[$];
    logic m_pending;
    int   m_result;
    logic m_zero;
    int   m_words;

    typedef struct {
        logic [1:0] d [TD];
        int         exp_val;
        logic       exp_zero;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dval(input logic [1:0] p);
        return int'(p[1]) - int'(p[0]);
    endfunction

    function automatic vec_t mkvec(input logic [1:0] a, input logic [1:0] b,
                                   input logic [1:0] c, input logic [1:0] e,
                                   input int v, input logic z);
        vec_t r;
        r.d[0] = a; r.d[1] = b; r.d[2] = c; r.d[3] = e;
        r.exp_val = v;
        r.exp_zero = z;
        return r;
    endfunction

    task automatic model_reset();
        word_q.delete();
        m_pending = 1'b0;
        m_result  = 0;
        m_zero    = 1'b0;
    endtask

    // One clock: called at a negedge, drives inputs, checks ready, advances to next negedge
    task automatic step(input logic v, input logic [1:0] p, input logic rr);
        logic exp_rdy;
        logic in_fire;
        logic out_fire;
        int   s;
        logic z;
        data_in_vld = v;
        p_value     = p;
        result_rdy  = rr;
        #1;
        exp_rdy  = !m_pending || rr;
        chk("data_in_rdy", int'(data_in_rdy), int'(exp_rdy));
        out_fire = m_pending && rr;
        in_fire  = v && exp_rdy;
        @(negedge clk);
        if (out_fire) m_pending = 1'b0;
        if (in_fire) begin
            word_q.push_back(dval(p));
            if (word_q.size() == TD) begin
                s = 0;
                z = 1'b1;
                foreach (word_q[i]) begin
                    s += word_q[i] * (1 << (TD - 1 - i));
                    if (word_q[i] != 0) z = 1'b0;
                end
                m_result  = s;
                m_zero    = z;
                m_pending = 1'b1;
                m_words++;
                word_q.delete();
            end
        end
        chk("result_vld", int'(result_vld), int'(m_pending));
        if (m_pending) begin
            chk("result", int'($signed(result)), m_result);
`ifdef OTF_ZERO_FLAG_EN
            chk("result_zero", int'(result_zero), int'(m_zero));
`endif
        end
    endtask

    initial begin
        int target;
        asyn_reset  = 1'b0;
        data_in_vld = 1'b0;
        p_value     = DIG_ZERO;
        result_rdy  = 1'b0;
        m_words     = 0;
        model_reset();

        tbl[0] = mkvec(DIG_POS,  DIG_ZERO, DIG_NEG,  DIG_POS,    7, 1'b0);
        tbl[1] = mkvec(DIG_NEG,  DIG_NEG,  DIG_NEG,  DIG_NEG,  -15, 1'b0);
        tbl[2] = mkvec(DIG_ZERO, 2'b11,    DIG_ZERO, DIG_ZERO,   0, 1'b1);
        tbl[3] = mkvec(DIG_POS,  DIG_POS,  DIG_POS,  DIG_POS,   15, 1'b0);
        tbl[4] = mkvec(DIG_NEG,  DIG_POS,  DIG_ZERO, DIG_ZERO,  -4, 1'b0);
        tbl[5] = mkvec(DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_NEG,   -1, 1'b0);
        tbl[6] = mkvec(DIG_POS,  DIG_NEG,  DIG_NEG,  DIG_NEG,    1, 1'b0);

        // Reset state
        @(negedge clk);
        chk("rst_result", int'(result), 0);
        chk("rst_result_vld", int'(result_vld), 0);
        chk("rst_data_in_rdy", int'(data_in_rdy), 1);
`ifdef OTF_ZERO_FLAG_EN
        chk("rst_result_zero", int'(result_zero), 0);
`endif
        asyn_reset = 1'b1;
        @(negedge clk);

        // Table vectors, vld held high, consumer always ready
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < TD; i++) step(1'b1, tbl[k].d[i], 1'b1);
            chk("tbl_vld", int'(result_vld), 1);
            chk("tbl_val", int'($signed(result)), tbl[k].exp_val);
`ifdef OTF_ZERO_FLAG_EN
            chk("tbl_zero", int'(result_zero), int'(tbl[k].exp_zero));
`endif
            step(1'b0, DIG_ZERO, 1'b1);
            chk("tbl_vld_one_cycle", int'(result_vld), 0);
        end

        // Back-pressure: result held for 5 cycles, then both transfers in one cycle
        step(1'b1, DIG_POS, 1'b1);
        step(1'b1, DIG_POS, 1'b1);
        step(1'b1, DIG_ZERO, 1'b1);
        step(1'b1, DIG_NEG, 1'b1);
        chk("bp_word", int'($signed(result)), 11);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, DIG_POS, 1'b0);
            chk("bp_hold", int'($signed(result)), 11);
        end
        step(1'b1, DIG_NEG, 1'b1);
        chk("bp_exit_vld", int'(result_vld), 0);
        step(1'b1, DIG_POS, 1'b1);
        step(1'b1, DIG_POS, 1'b1);
        step(1'b1, DIG_ZERO, 1'b1);
        chk("bp_next_word", int'($signed(result)), -2);
        step(1'b0, DIG_ZERO, 1'b1);

        // Reset after 2 of 4 digits discards the partial word
        step(1'b1, DIG_NEG, 1'b1);
        step(1'b1, DIG_NEG, 1'b1);
        asyn_reset = 1'b0;
        #1;
        chk("midrst_result", int'(result), 0);
        chk("midrst_vld", int'(result_vld), 0);
        chk("midrst_rdy", int'(data_in_rdy), 1);
        model_reset();
        @(negedge clk);
        asyn_reset = 1'b1;
        for (int i = 0; i < TD; i++) step(1'b1, DIG_POS, 1'b1);
        chk("postrst_word", int'($signed(result)), 15);

        // Reset while holding a result in DONE
        step(1'b0, DIG_ZERO, 1'b0);
        asyn_reset = 1'b0;
        #1;
        chk("donerst_vld", int'(result_vld), 0);
        model_reset();
        @(negedge clk);
        asyn_reset = 1'b1;

        // Randomized digits, input gaps and output back-pressure
        target = m_words + 1000;
        for (int c = 0; c < 40000 && m_words < target; c++) begin
            step(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 3) != 0));
        end
        chk("random_words_done", int'(m_words >= target), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
